// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: carries instr/pc/npc from fetch to decode under a
// valid/ready handshake. Supports decode stall, synchronous flush, and an
// optional skid entry (SKID=1) that makes in_ready a registered signal.
// Optional performance counters are enabled by defining IF_ID_PERF_EN.
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | no entry held, out_valid=0, out_instr=NOP
// ONE   | main entry valid, skid empty
// TWO   | main and skid entries valid (SKID=1 only)
module if_id_pipe_reg #(
  parameter int unsigned     XLEN = 32,
  parameter int unsigned     ILEN = 32,
  parameter logic [ILEN-1:0] NOP  = 32'h00000013,
  parameter bit              SKID = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_npc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_npc
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [15:0]     flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ILEN-1:0] main_instr, skid_instr;
  logic [XLEN-1:0] main_pc, skid_pc;
  logic [XLEN-1:0] main_npc, skid_npc;

  logic in_xfer;
  logic out_xfer;

  // Handshake qualifiers; a flush drops any incoming word.
  always_comb begin
    in_xfer  = in_valid & in_ready & ~flush;
    out_xfer = out_valid & out_ready;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) state_nxt = ONE;
        end
        ONE: begin
          if (in_xfer && out_xfer)       state_nxt = ONE;
          else if (in_xfer && SKID)      state_nxt = TWO;
          else if (out_xfer)             state_nxt = EMPTY;
        end
        TWO: begin
          if (out_xfer) state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Output logic; the bubble word replaces the held instruction when idle.
  always_comb begin
    out_valid = (state != EMPTY);
    out_instr = out_valid ? main_instr : NOP;
    out_pc    = main_pc;
    out_npc   = main_npc;
  end

  // Datapath: main takes the incoming word or drains from skid; skid catches
  // a word that arrives while main is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_instr <= NOP;
      main_pc    <= '0;
      main_npc   <= '0;
      skid_instr <= NOP;
      skid_pc    <= '0;
      skid_npc   <= '0;
    end else if (!flush) begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
            main_npc   <= in_npc;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
            main_npc   <= in_npc;
          end else if (in_xfer) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
            skid_npc   <= in_npc;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
            main_npc   <= skid_npc;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    if (SKID) begin : g_skid
      logic in_ready_q;

      // Registered ready: low only while both entries are occupied, so there
      // is no combinational path from out_ready to in_ready.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_nxt != TWO);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

`ifdef IF_ID_PERF_EN
  // Saturating counters for decode stalls and flushes that killed an entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && out_valid && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
